// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and defaults for the two-digit 7-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        BLANK_LO = 2'd0,
        SHOW_LO  = 2'd1,
        BLANK_HI = 2'd2,
        SHOW_HI  = 2'd3
    } scan_state_e;

    localparam logic DIG_LO = 1'b0;
    localparam logic DIG_HI = 1'b1;

    localparam int DEF_REFRESH_DIV  = 100000;
    localparam int DEF_BLANK_CYC    = 1000;
    localparam int DEF_BLINK_FRAMES = 64;
    localparam int DEF_CNT_W        = 17;

    function automatic logic is_hi(input scan_state_e s);
        return (s == BLANK_HI) || (s == SHOW_HI);
    endfunction

    function automatic logic is_blank_state(input scan_state_e s);
        return (s == BLANK_LO) || (s == BLANK_HI);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Byte write channel from the PS/AXI-side writer into the scan controller.
interface seg_scan_ctrl_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_en, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_data, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Per-digit slot counter: strobes the last blanked cycle and the last cycle of the slot.
module seg_slot_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int CNT_W       = 17
) (
    input  logic clk,
    input  logic resetn,
    output logic o_blank_done,
    output logic o_slot_wrap
);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_cnt <= '0;
        else if (o_slot_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_slot_wrap  = (r_cnt == SLOT_LAST);
    // With no blanking window there is no blanked cycle to finish.
    assign o_blank_done = (BLANK_CYC > 0) && (r_cnt == BLANK_LAST);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit hex display scanner: digit alternation, anti-ghost blanking,
// frame-aligned double-buffered byte commit and whole-display blinking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLANK_CYC    = DEF_BLANK_CYC,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    seg_scan_ctrl_if.slave        wr_if,
    input  logic                  blink_en,
    output logic                  c,
    output logic [7:0]            wdata,
    output logic                  blank,
    output logic                  frame_tick
);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam scan_state_e RST_STATE = (BLANK_CYC == 0) ? SHOW_LO : BLANK_LO;
    localparam scan_state_e LO_ENTRY  = (BLANK_CYC == 0) ? SHOW_LO : BLANK_LO;
    localparam scan_state_e HI_ENTRY  = (BLANK_CYC == 0) ? SHOW_HI : BLANK_HI;

    scan_state_e     r_state, w_next;
    logic            w_blank_done, w_slot_wrap, w_frame_tick, w_phase_nxt;
    logic            r_c, r_blank, r_blink_phase, r_pend_valid;
    logic [7:0]      r_wdata, r_pend;
    logic [FC_W-1:0] r_frame_cnt;

    seg_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .o_blank_done (w_blank_done),
        .o_slot_wrap  (w_slot_wrap)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= RST_STATE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BLANK_LO: if (w_blank_done) w_next = SHOW_LO;
            SHOW_LO:  if (w_slot_wrap)  w_next = HI_ENTRY;
            BLANK_HI: if (w_blank_done) w_next = SHOW_HI;
            SHOW_HI:  if (w_slot_wrap)  w_next = LO_ENTRY;
            default:                    w_next = RST_STATE;
        endcase
    end

    assign w_frame_tick = (r_state == SHOW_HI) && w_slot_wrap;
    assign w_phase_nxt  = r_blink_phase ^ (w_frame_tick && (r_frame_cnt == FRAME_LAST));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_tick) begin
            r_frame_cnt   <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + FC_W'(1);
            r_blink_phase <= w_phase_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_c     <= DIG_LO;
            r_blank <= 1'b1;
        end else begin
            r_c     <= is_hi(w_next) ? DIG_HI : DIG_LO;
            r_blank <= is_blank_state(w_next) || (blink_en && w_phase_nxt);
        end
    end

    // A commit at the boundary takes priority; a write can only land when pending is empty.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wdata      <= 8'h00;
            r_pend       <= 8'h00;
            r_pend_valid <= 1'b0;
        end else if (w_frame_tick && r_pend_valid) begin
            r_wdata      <= r_pend;
            r_pend_valid <= 1'b0;
        end else if (wr_if.wr_en && !r_pend_valid) begin
            r_pend       <= wr_if.wr_data;
            r_pend_valid <= 1'b1;
        end
    end

    assign wr_if.wr_ready = ~r_pend_valid;
    assign c              = r_c;
    assign wdata          = r_wdata;
    assign blank          = r_blank;
    assign frame_tick     = w_frame_tick;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: stimulus pushes expected commits into a queue,
// a negedge monitor checks scan timing every cycle and pops on each wdata change.
module tb_seg_scan_ctrl;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int CW    = 3;
    localparam int FRAME = 2 * RD;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       blink_en = 1'b0;
    logic       c, blank, frame_tick;
    logic [7:0] wdata;

    seg_scan_ctrl_if wr_if ();

    seg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_if      (wr_if),
        .blink_en   (blink_en),
        .c          (c),
        .wdata      (wdata),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   t = 0;
    bit   had_rst = 1'b0;
    bit   rst_edge = 1'b0;
    bit   blink_d = 1'b0;
    logic [7:0] prev_wdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Cycle index since the last reset, matching the DUT's slot counter origin.
    always @(posedge clk) begin
        t        <= resetn ? t + 1 : 0;
        rst_edge <= !resetn;
        blink_d  <= blink_en;
        if (!resetn) had_rst <= 1'b1;
    end

    always @(negedge clk) begin
        logic ec, eb, ef, ph;
        exp_t e;
        if (had_rst) begin
            ph = ((t / (FRAME * BF)) % 2) == 1;
            ec = (t % FRAME) >= RD;
            eb = ((t % RD) < BC) || (blink_d && ph);
            ef = (t % FRAME) == FRAME - 1;
            check("scan{c,blank,tick}", {29'd0, c, blank, frame_tick}, {29'd0, ec, eb, ef});
            if (rst_edge) begin
                check("reset_wdata", {24'd0, wdata}, 32'h00);
                check("reset_wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
            end else if (wdata !== prev_wdata) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL commit: unexpected wdata %0h, expected no change (t=%0d)", wdata, t);
                end else begin
                    e = sb.pop_front();
                    check("commit_data", {24'd0, wdata}, {24'd0, e.data});
                    check("commit_time", t, e.t);
                    check("commit_wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
                end
            end
            prev_wdata = wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        sb.delete();
        repeat (n) tick();
        resetn = 1'b1;
    endtask

    task automatic wait_phase(input int m);
        for (int k = 0; k < 64 && (t % FRAME) != m; k++) tick();
        check("wait_phase", t % FRAME, m);
    endtask

    // Holds wr_en until accepted; expected visibility is the cycle after the next boundary.
    task automatic write_byte(input logic [7:0] d);
        bit done = 1'b0;
        int b;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = d;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (wr_if.wr_ready) begin
                b = t + 1;
                while ((b % FRAME) != FRAME - 1) b++;
                sb.push_back('{d, b + 1});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        wr_if.wr_en = 1'b0;
        if (!done) check("write_accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_data = 8'h00;

        // 1: reset and free-running scan
        do_reset(3);
        repeat (34) tick();

        // 2: single write mid-LO slot
        wait_phase(3);
        write_byte(8'hA5);
        @(negedge clk);
        check("wr_ready_drop", {31'd0, wr_if.wr_ready}, 32'd0);
        repeat (40) tick();

        // 3: back-to-back writes, second held off until the first commits
        wait_phase(5);
        write_byte(8'h12);
        write_byte(8'h34);
        repeat (40) tick();

        // 4: write on the exact boundary while pending is full
        wait_phase(4);
        write_byte(8'h11);
        wait_phase(FRAME - 1);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = 8'h7E;
        @(negedge clk);
        check("boundary_tick", {31'd0, frame_tick}, 32'd1);
        check("boundary_refuse", {31'd0, wr_if.wr_ready}, 32'd0);
        tick();
        write_byte(8'h7E);
        repeat (40) tick();

        // 5: blinking, then back to slot blanking only
        do_reset(3);
        blink_en = 1'b1;
        repeat (130) tick();
        blink_en = 1'b0;
        repeat (40) tick();

        // 6: reset in SHOW_HI with a pending byte discards it
        wait_phase(2);
        write_byte(8'h5C);
        wait_phase(12);
        do_reset(1);
        @(negedge clk);
        check("post_reset_wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        check("post_reset_wdata", {24'd0, wdata}, 32'h00);
        repeat (40) tick();

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
